// File: rtl/rowbuffer_reader.sv
// Read-side controller for the ping-pong row buffer: streams row_count consecutive rows
// from the selected bank to the feature adder, hiding RAM read latency behind a credit-limited FIFO.
module rowbuffer_reader #(
  parameter int dataWidth    = 32,
  parameter int pvadd        = 256,
  parameter int k            = 1024,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int addressWidth = $clog2(k),
  localparam int rowWidth     = dataWidth * pvadd
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addressWidth-1:0] base_addr,
  input  logic [addressWidth:0]   row_count,
  input  logic                    bank_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    enableA,
  output logic                    enableB,
  output logic [addressWidth-1:0] addressportA1,
  output logic [addressWidth-1:0] addressportB1,
  input  logic [rowWidth-1:0]     readportA1,
  input  logic [rowWidth-1:0]     readportB1,
  output logic [rowWidth-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [addressWidth:0]   CNT_ONE  = 1;
  localparam logic [addressWidth-1:0] ADDR_ONE = 1;
  localparam logic [addressWidth-1:0] ADDR_MAX = addressWidth'(k - 1);
  localparam logic [PW-1:0]           PTR_ONE  = 1;
  localparam logic [PW-1:0]           PTR_MAX  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic [addressWidth:0]   issued_q, issued_d;
  logic [addressWidth:0]   count_q, count_d;
  logic                    bank_q, bank_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           fifo_count_q, fifo_count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0]       tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0]       tag_last_q, tag_last_d;
  logic [rowWidth-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic                    fifo_last_q [FIFO_DEPTH];

  logic                credit_ok, issue, issue_last;
  logic                ret, ret_last, fifo_empty;
  logic                pop, fifo_wr, fifo_rd;
  logic [rowWidth-1:0] ret_data, head_data;
  logic                head_last;

  // Tag pipe mirrors the RAM latency: the oldest stage marks the row arriving this cycle.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_vld_d[gi]  = issue;
      assign tag_last_d[gi] = issue_last;
    end else begin : g_body
      assign tag_vld_d[gi]  = tag_vld_q[gi-1];
      assign tag_last_d[gi] = tag_last_q[gi-1];
    end
  end

  assign ret        = tag_vld_q[RD_LAT-1];
  assign ret_last   = tag_last_q[RD_LAT-1];
  assign ret_data   = bank_q ? readportB1 : readportA1;
  assign fifo_empty = (fifo_count_q == '0);
  assign credit_ok  = (inflight_q + fifo_count_q) < CW'(FIFO_DEPTH);

  // An empty FIFO passes the returning row straight through; it is stored only if not taken.
  assign head_data = fifo_empty ? ret_data : fifo_mem_q[rd_ptr_q];
  assign head_last = fifo_empty ? ret_last : fifo_last_q[rd_ptr_q];
  assign out_valid = !fifo_empty || ret;
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid && head_last;
  assign pop       = out_valid && out_ready;
  assign fifo_wr   = ret && !(fifo_empty && pop);
  assign fifo_rd   = pop && !fifo_empty;

  assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign enableA       = issue && !bank_q;
  assign enableB       = issue && bank_q;
  assign addressportA1 = enableA ? addr_q : '0;
  assign addressportB1 = enableB ? addr_q : '0;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    count_d    = count_q;
    bank_d     = bank_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          count_d  = row_count;
          bank_d   = bank_sel;
          issued_d = '0;
          state_d  = (row_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue    = 1'b1;
          addr_d   = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_ONE;
          issued_d = issued_q + CNT_ONE;
          if (issued_q + CNT_ONE == count_q) begin
            issue_last = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      // Beats leave in order, so accepting the last one means nothing is left in flight.
      S_DRAIN: if (pop && head_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d   = inflight_q + CW'(issue) - CW'(ret);
    fifo_count_d = fifo_count_q + CW'(fifo_wr) - CW'(fifo_rd);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_ONE;
    if (fifo_rd) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issued_q     <= '0;
      count_q      <= '0;
      bank_q       <= 1'b0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_vld_q    <= '0;
      tag_last_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issued_q     <= issued_d;
      count_q      <= count_d;
      bank_q       <= bank_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_last_q   <= tag_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem_q[wr_ptr_q]  <= ret_data;
      fifo_last_q[wr_ptr_q] <= ret_last;
    end
  end

endmodule

// File: tb/tb_rowbuffer_reader.sv
// Bench for rowbuffer_reader: bank RAM models with RD_LAT latency, a queue-based model of
// the expected issue/beat sequence, one compare process on the falling edge, directed jobs.
module tb_rowbuffer_reader;
  localparam int DW = 32, PV = 2, K = 1024, RD_LAT = 2, DEPTH = 4;
  localparam int AW = $clog2(K), RW = DW * PV;
  localparam logic [RW-1:0] FILL = 64'hDEAD_DEAD_DEAD_DEAD;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, bank_sel = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   row_count = '0;
  logic          busy, done, enableA, enableB, out_valid, out_last;
  logic [AW-1:0] addressportA1, addressportB1;
  logic [RW-1:0] readportA1, readportB1, out_data;

  rowbuffer_reader #(.dataWidth(DW), .pvadd(PV), .k(K), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .bank_sel(bank_sel), .busy(busy), .done(done), .enableA(enableA), .enableB(enableB),
    .addressportA1(addressportA1), .addressportB1(addressportB1),
    .readportA1(readportA1), .readportB1(readportB1), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank RAMs: data for an address presented in cycle c is on the read port in cycle c+RD_LAT.
  logic [RW-1:0] mem_a [K];
  logic [RW-1:0] mem_b [K];
  logic [RW-1:0] pipe_a [RD_LAT];
  logic [RW-1:0] pipe_b [RD_LAT];
  always @(posedge clk) begin
    pipe_a[0] <= enableA ? mem_a[addressportA1] : FILL;
    pipe_b[0] <= enableB ? mem_b[addressportB1] : FILL;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign readportA1 = pipe_a[RD_LAT-1];
  assign readportB1 = pipe_b[RD_LAT-1];

  typedef struct packed {logic [RW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic bank; logic [AW-1:0] addr;} iss_t;
  beat_t exp_q[$];
  iss_t  iss_q[$];
  bit    model_active = 0;
  int    n_pass = 0, n_total = 0;
  int    outstanding = 0, done_cnt = 0;
  int    job_cyc, first_v_cyc, done_cyc, job_beats, job_lasts, job_en_a, job_en_b;
  logic [RW-1:0] first_data, last_data, prev_d;
  logic  prev_v = 0, prev_r = 0, prev_l = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Model: an accepted job reads rows base..base+n-1 modulo K, in order, last flag on row n.
  task automatic model_start(input int b, input int n, input logic bk);
    logic [AW-1:0] a;
    if (model_active) return;
    model_active = 1;
    job_cyc = cyc; first_v_cyc = -1; done_cyc = -1;
    job_beats = 0; job_lasts = 0; job_en_a = 0; job_en_b = 0;
    first_data = '0; last_data = '0;
    for (int i = 0; i < n; i++) begin
      a = AW'((b + i) % K);
      iss_q.push_back({bk, a});
      exp_q.push_back({(bk ? mem_b[a] : mem_a[a]), (i == n - 1)});
    end
  endtask

  always @(negedge clk) begin
    iss_t  ei;
    beat_t eb;
    if (rst) begin
      prev_v = 0;
    end else begin
      if (enableA || enableB) begin
        if (enableA) job_en_a++;
        if (enableB) job_en_b++;
        chk("single_bank_enable", {enableA, enableB} == 2'b11, 0);
        if (iss_q.size() == 0) chk("spurious_issue", 1, 0);
        else begin
          ei = iss_q.pop_front();
          chk("issue_bank", enableB, ei.bank);
          chk("issue_addr", enableB ? addressportB1 : addressportA1, ei.addr);
        end
        outstanding++;
      end
      if (prev_v && !prev_r)
        chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_l, prev_d});
      if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (out_valid && out_ready) begin
        outstanding--;
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          eb = exp_q.pop_front();
          chk("beat_data", out_data, eb.data);
          chk("beat_last", out_last, eb.last);
        end
        if (job_beats == 0) first_data = out_data;
        if (out_last) begin job_lasts++; last_data = out_data; end
        job_beats++;
        $display("beat cycle=%0d data=%h last=%0b", cyc - job_cyc, out_data, out_last);
      end
      if (model_active) chk("credit_limit", outstanding <= DEPTH, 1);
      if (done) begin
        chk("done_clean", {model_active, exp_q.size() == 0, iss_q.size() == 0, busy}, 4'b1110);
        model_active = 0;
        done_cyc = cyc;
        done_cnt++;
      end
      prev_v = out_valid; prev_r = out_ready; prev_l = out_last; prev_d = out_data;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_ctrl", {busy, done, enableA, enableB, out_valid, out_last}, 6'b0);
    chk("rst_addr", {addressportA1, addressportB1}, '0);
    chk("rst_data", out_data, '0);
  endtask

  // Called in the cycle rst goes high; checks the cycle after the reset edge, flushes the model.
  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete(); iss_q.delete();
    model_active = 0; outstanding = 0;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic run_job(input int b, input int n, input logic bk, input bit bp,
                         input bit ign, input int rst_at);
    int d0;
    @(posedge clk); #1;
    base_addr = AW'(b); row_count = (AW+1)'(n); bank_sel = bk; start = 1'b1;
    out_ready = 1'b1;
    model_start(b, n, bk);
    d0 = done_cnt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) break;
      start = 1'b0;
      if (bp) out_ready = ((cyc - job_cyc) % 4 == 0) || ((cyc - job_cyc) % 4 == 3);
      if (ign && i == 2) begin
        base_addr = AW'(7); row_count = (AW+1)'(3); bank_sel = ~bk; start = 1'b1;
        model_start(7, 3, ~bk);
      end
      if (rst_at > 0 && cyc - job_cyc == rst_at) begin
        do_reset();
        return;
      end
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < K; i++) begin
      mem_a[i] = RW'(i);
      mem_b[i] = {32'hB0B0_0000, 32'(i)};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_job(4, 8, 1'b0, 0, 0, 0);
    chk("t1_first_valid_cycle", first_v_cyc - job_cyc, 3);
    chk("t1_done_cycle", done_cyc - job_cyc, 11);
    chk("t1_first_data", first_data, 64'd4);
    chk("t1_last_data", last_data, 64'd11);
    chk("t1_beats", job_beats, 8);
    chk("t1_last_count", job_lasts, 1);
    chk("t1_no_enableB", job_en_b, 0);

    run_job(1020, 6, 1'b1, 0, 0, 0);
    chk("t2_first_data", first_data, 64'hB0B0_0000_0000_03FC);
    chk("t2_last_data", last_data, 64'hB0B0_0000_0000_0001);
    chk("t2_beats", job_beats, 6);
    chk("t2_no_enableA", job_en_a, 0);
    chk("t2_done_cycle", done_cyc - job_cyc, 9);

    run_job(100, 10, 1'b0, 1, 0, 0);
    chk("t3_beats", job_beats, 10);
    chk("t3_last_data", last_data, 64'd109);
    chk("t3_last_count", job_lasts, 1);

    run_job(5, 0, 1'b0, 0, 0, 0);
    chk("t4_no_enable", job_en_a + job_en_b, 0);
    chk("t4_no_beats", job_beats, 0);
    chk("t4_done_by_cycle2", (done_cyc - job_cyc >= 1) && (done_cyc - job_cyc <= 2), 1);

    run_job(20, 8, 1'b0, 0, 1, 0);
    chk("t5_beats", job_beats, 8);
    chk("t5_no_enableB", job_en_b, 0);
    chk("t5_done_cycle", done_cyc - job_cyc, 11);

    run_job(0, 16, 1'b0, 0, 0, 5);
    repeat (3) @(posedge clk);
    run_job(0, 2, 1'b0, 0, 0, 0);
    chk("t6_beats", job_beats, 2);
    chk("t6_first_data", first_data, 64'd0);
    chk("t6_last_data", last_data, 64'd1);
    chk("model_drained", {exp_q.size() == 0, iss_q.size() == 0}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
